d_latch_bank: RTL and testbench

Parametrised multi-channel storage bank that succeeds the single-bit D latch. It holds CHANNELS independent WIDTH-bit registers, updated synchronously under an enable with four selectable write modes: load, edge-capture, toggle and clear. Every accepted update is logged into a DEPTH-entry history FIFO that a host drains through a valid/ready handshake. It sits behind the tile's dedicated inputs as a general-purpose state-holding element with change tracking.

---
 rtl/d_latch_bank_if.sv | 33 +++
 rtl/d_latch_bank.sv | 102 ++++++++++
 tb/tb_d_latch_bank.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/d_latch_bank_if.sv
// Host-side bus of the channel bank: write port, history FIFO handshake and overflow flag.
// The host drives through the master modport; the bank implements the slave.
interface d_latch_bank_if #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DEPTH    = 4
);
   localparam int unsigned SelW = $clog2(CHANNELS);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0]          d;
   logic [SelW-1:0]           sel;
   logic                      en;
   logic [1:0]                mode;
   logic [CHANNELS*WIDTH-1:0] q_all;
   logic                      hist_valid;
   logic [SelW-1:0]           hist_ch;
   logic [WIDTH-1:0]          hist_data;
   logic                      hist_ready;
   logic [CntW-1:0]           hist_count;
   logic                      ovf;
   logic                      ovf_clr;

   modport master (
      output d, sel, en, mode, hist_ready, ovf_clr,
      input  q_all, hist_valid, hist_ch, hist_data, hist_count, ovf
   );

   modport slave (
      input  d, sel, en, mode, hist_ready, ovf_clr,
      output q_all, hist_valid, hist_ch, hist_data, hist_count, ovf
   );
endinterface

// File: rtl/d_latch_bank.sv
// Multi-channel register bank with load/edge/toggle/clear writes; every accepted write is
// logged as {channel, new value} into a small history FIFO with a sticky overflow flag.
module d_latch_bank #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DEPTH    = 4
) (
   input logic           clk,
   input logic           rst,
   d_latch_bank_if.slave bus
);
   localparam int unsigned SelW = $clog2(CHANNELS);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {
      ModeLoad   = 2'b00,
      ModeEdge   = 2'b01,
      ModeToggle = 2'b10,
      ModeClear  = 2'b11
   } mode_e;

   logic [WIDTH-1:0] ch_q       [CHANNELS];
   logic [SelW-1:0]  mem_ch_q   [DEPTH];
   logic [WIDTH-1:0] mem_data_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q, count_d;
   logic             en_d_q;
   logic             ovf_q, ovf_d;
   logic             accept, push, pop, full, valid;
   logic [WIDTH-1:0] new_val;
   mode_e            mode;

   always_comb begin
      mode    = mode_e'(bus.mode);
      accept  = bus.en;
      new_val = bus.d;
      case (mode)
         ModeLoad:   ;
         ModeEdge:   accept = bus.en & ~en_d_q;
         ModeToggle: new_val = ch_q[bus.sel] ^ bus.d;
         ModeClear:  new_val = '0;
         default:    ;
      endcase

      valid = (count_q != '0);
      full  = (count_q == CntW'(DEPTH));
      pop   = valid & bus.hist_ready;
      // A full FIFO still takes the push when the head leaves in the same cycle.
      push  = accept & (~full | pop);
      ovf_d = (ovf_q & ~bus.ovf_clr) | (accept & full & ~pop);

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_q
      assign bus.q_all[i*WIDTH +: WIDTH] = ch_q[i];
   end

   assign bus.hist_valid = valid;
   assign bus.hist_ch    = valid ? mem_ch_q[rd_ptr_q]   : '0;
   assign bus.hist_data  = valid ? mem_data_q[rd_ptr_q] : '0;
   assign bus.hist_count = count_q;
   assign bus.ovf        = ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_d_q   <= 1'b0;
         ovf_q    <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            ch_q[i] <= '0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            mem_ch_q[i]   <= '0;
            mem_data_q[i] <= '0;
         end
      end else begin
         en_d_q  <= bus.en;
         ovf_q   <= ovf_d;
         count_q <= count_d;
         if (accept) begin
            ch_q[bus.sel] <= new_val;
         end
         if (push) begin
            mem_ch_q[wr_ptr_q]   <= bus.sel;
            mem_data_q[wr_ptr_q] <= new_val;
            wr_ptr_q             <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_d_latch_bank.sv
// Randomised and directed bench for d_latch_bank: a queue-based reference model predicts log
// entries at issue time; a negedge monitor compares each popped head against the queue.
module tb_d_latch_bank;
   localparam int unsigned WIDTH    = 8;
   localparam int unsigned CHANNELS = 4;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned SelW     = $clog2(CHANNELS);
   localparam logic [1:0] LD = 2'd0, EG = 2'd1, TG = 2'd2, CL = 2'd3;

   typedef struct packed {
      logic [SelW-1:0]  ch;
      logic [WIDTH-1:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   d_latch_bank_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) bus ();

   d_latch_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [WIDTH-1:0] ch_m [CHANNELS];
   ent_t             exp_q[$];
   logic             ovf_m;
   logic             en_d_m;
   int               n_vec = 0;
   int               n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < CHANNELS; i++) ch_m[i] = '0;
      exp_q.delete();
      ovf_m  = 1'b0;
      en_d_m = 1'b0;
   endtask

   task automatic check_state();
      logic [CHANNELS*WIDTH-1:0] qe;
      for (int i = 0; i < CHANNELS; i++) qe[i*WIDTH +: WIDTH] = ch_m[i];
      chk("q_all", 64'(bus.q_all), 64'(qe));
      chk("hist_count", 64'(bus.hist_count), 64'(exp_q.size()));
      chk("hist_valid", 64'(bus.hist_valid), 64'(exp_q.size() != 0));
      chk("ovf", 64'(bus.ovf), 64'(ovf_m));
      if (exp_q.size() == 0) begin
         chk("empty_ch", 64'(bus.hist_ch), 64'd0);
         chk("empty_data", 64'(bus.hist_data), 64'd0);
      end
   endtask

   // Called just after a rising edge; applies one cycle of stimulus and predicts its effect.
   task automatic cyc(input logic e, input logic [1:0] m, input logic [SelW-1:0] s,
                      input logic [WIDTH-1:0] dv, input logic rdy, input logic oc);
      logic             acc, full, popw;
      logic [WIDTH-1:0] nv;
      ent_t             ent;
      check_state();
      bus.en = e; bus.mode = m; bus.sel = s; bus.d = dv;
      bus.hist_ready = rdy; bus.ovf_clr = oc;
      acc  = e && (m != EG || !en_d_m);
      nv   = (m == LD || m == EG) ? dv : (m == TG) ? (ch_m[s] ^ dv) : '0;
      full = (exp_q.size() >= DEPTH);
      popw = rdy && (exp_q.size() > 0);
      if (acc) begin
         ch_m[s] = nv;
         if (!full || popw) begin
            ent.ch = s; ent.data = nv;
            exp_q.push_back(ent);
         end
      end
      if (acc && full && !popw) ovf_m = 1'b1;
      else if (oc) ovf_m = 1'b0;
      en_d_m = e;
      @(posedge clk); #1;
   endtask

   task automatic idle(input logic rdy);
      cyc(1'b0, LD, '0, '0, rdy, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i <= DEPTH; i++) idle(1'b1);
   endtask

   // Monitor: a pop happens at the next rising edge whenever valid and ready are both high.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.hist_valid && bus.hist_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL unexpected_pop: got ch=%0h data=%0h, expected no entry",
                        bus.hist_ch, bus.hist_data);
            end else begin
               chk("head_ch", 64'(bus.hist_ch), 64'(exp_q[0].ch));
               chk("head_data", 64'(bus.hist_data), 64'(exp_q[0].data));
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      bus.en = 1'b0; bus.mode = LD; bus.sel = '0; bus.d = '0;
      bus.hist_ready = 1'b0; bus.ovf_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q_all", 64'(bus.q_all), 64'd0);
      chk("rst_count", 64'(bus.hist_count), 64'd0);
      rst = 1'b0;
      idle(1'b0);

      // LOAD
      cyc(1'b1, LD, 2'd2, 8'hA5, 1'b0, 1'b0);
      chk("ld_ch2", 64'(bus.q_all[2*WIDTH +: WIDTH]), 64'hA5);
      chk("ld_head", 64'({bus.hist_ch, bus.hist_data}), 64'h2A5);
      drain();

      // EDGE held high with changing data
      cyc(1'b1, EG, 2'd1, 8'h11, 1'b0, 1'b0);
      cyc(1'b1, EG, 2'd1, 8'h22, 1'b0, 1'b0);
      cyc(1'b1, EG, 2'd1, 8'h33, 1'b0, 1'b0);
      cyc(1'b1, EG, 2'd3, 8'h33, 1'b0, 1'b0);
      cyc(1'b1, EG, 2'd1, 8'h33, 1'b0, 1'b0);
      idle(1'b0);
      chk("edge_ch1", 64'(bus.q_all[1*WIDTH +: WIDTH]), 64'h11);
      chk("edge_count", 64'(bus.hist_count), 64'd1);
      cyc(1'b1, EG, 2'd1, 8'h44, 1'b0, 1'b0);
      idle(1'b0);
      chk("edge_rearm", 64'(bus.q_all[1*WIDTH +: WIDTH]), 64'h44);
      drain();

      // TOGGLE / CLEAR
      cyc(1'b1, LD, 2'd0, 8'hF0, 1'b0, 1'b0);
      drain();
      cyc(1'b1, TG, 2'd0, 8'hFF, 1'b0, 1'b0);
      chk("tog1", 64'(bus.q_all[WIDTH-1:0]), 64'h0F);
      cyc(1'b1, TG, 2'd0, 8'h0F, 1'b0, 1'b0);
      cyc(1'b1, CL, 2'd0, 8'h5C, 1'b0, 1'b0);
      idle(1'b0);
      chk("tgcl_count", 64'(bus.hist_count), 64'd3);
      drain();

      // Overflow, then clear, then concurrent clear and overflow
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, LD, SelW'(i % CHANNELS), WIDTH'($urandom), 1'b0, 1'b0);
      end
      idle(1'b0);
      chk("ovf_count", 64'(bus.hist_count), 64'(DEPTH));
      chk("ovf_set", 64'(bus.ovf), 64'd1);
      cyc(1'b0, LD, '0, '0, 1'b0, 1'b1);
      chk("ovf_cleared", 64'(bus.ovf), 64'd0);
      cyc(1'b1, LD, 2'd1, 8'h3C, 1'b0, 1'b1);
      chk("ovf_set_wins", 64'(bus.ovf), 64'd1);
      cyc(1'b0, LD, '0, '0, 1'b0, 1'b1);

      // Full FIFO with simultaneous push and pop
      cyc(1'b1, LD, 2'd3, 8'h77, 1'b1, 1'b0);
      chk("pp_count", 64'(bus.hist_count), 64'(DEPTH));
      chk("pp_ovf", 64'(bus.ovf), 64'd0);
      drain();

      // Asynchronous reset between edges, released with en high in EDGE mode
      cyc(1'b1, LD, 2'd1, 8'h99, 1'b0, 1'b0);
      cyc(1'b1, LD, 2'd3, 8'h66, 1'b0, 1'b0);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("arst_q_all", 64'(bus.q_all), 64'd0);
      chk("arst_valid", 64'(bus.hist_valid), 64'd0);
      chk("arst_count", 64'(bus.hist_count), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(1'b1, EG, 2'd2, 8'h5A, 1'b0, 1'b0);
      chk("arst_edge", 64'(bus.q_all[2*WIDTH +: WIDTH]), 64'h5A);
      chk("arst_edge_count", 64'(bus.hist_count), 64'd1);
      drain();

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         cyc(logic'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
             SelW'($urandom_range(0, CHANNELS - 1)), WIDTH'($urandom),
             logic'($urandom_range(0, 1)), logic'($urandom_range(0, 7) == 0));
      end
      drain();
      check_state();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
